// File: rtl/mem_access_stage.sv
// Memory stage of the five-stage pipeline: data-memory access with byte-lane stores,
// sub-word load extension, misalignment detection and the MEM/WB register bundle.
module mem_access_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic               i_mem2reg,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [NB_REG-1:0]  i_write_reg,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_DATA-1:0] o_result,
    output logic [NB_REG-1:0]  o_write_reg,
    output logic               o_misaligned,
    output logic [NB_DATA-1:0] o_dbg_data
);

    localparam int DEPTH = 2 ** NB_ADDR;

    typedef enum logic [1:0] {
        W_BYTE = 2'b00,
        W_HALF = 2'b01,
        W_RSVD = 2'b10,
        W_WORD = 2'b11
    } width_e;

    logic [NB_DATA-1:0] r_mem [DEPTH];

    logic               r_mem2reg;
    logic               r_regWrite;
    logic [NB_DATA-1:0] r_result;
    logic [NB_REG-1:0]  r_write_reg;
    logic               r_misaligned;
    width_e             r_width;
    logic [1:0]         r_offset;
    logic               r_sign;
    logic [NB_DATA-1:0] r_rd_word;
    logic [NB_DATA-1:0] r_dbg_data;

    width_e             w_width;
    logic [NB_ADDR-1:0] w_word_idx;
    logic [1:0]         w_offset;
    logic               w_misaligned;
    logic               w_store_en;
    logic [3:0]         w_be;
    logic [NB_DATA-1:0] w_wdata;
    logic [7:0]         w_lane_byte;
    logic [15:0]        w_lane_half;
    logic [NB_DATA-1:0] w_load_ext;
    logic               w_unused;

    assign w_width    = width_e'(i_width);
    assign w_word_idx = i_result[NB_ADDR+1:2];
    assign w_offset   = i_result[1:0];
    // Address bits above the memory depth wrap around.
    assign w_unused   = ^i_result[NB_DATA-1:NB_ADDR+2];

    assign w_misaligned = (i_memWrite || i_mem2reg) &&
                          (((w_width == W_HALF) && w_offset[0]) ||
                           ((w_width == W_WORD || w_width == W_RSVD) && (w_offset != 2'b00)));

    assign w_store_en = i_reset && !i_halt && i_memWrite && !w_misaligned;

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_data4Mem;
        case (w_width)
            W_BYTE: begin
                w_be    = 4'b0001 << w_offset;
                w_wdata = {4{i_data4Mem[7:0]}};
            end
            W_HALF: begin
                w_be    = w_offset[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_data4Mem[15:0]}};
            end
            default: ;
        endcase
    end

    // NOTE: the memory array has no reset; clearing it would force a flop-based array
    // and its contents must survive a pipeline reset anyway.
    always_ff @(posedge clk) begin
        if (w_store_en) begin
            for (int l = 0; l < 4; l++) begin
                if (w_be[l]) r_mem[w_word_idx][8*l +: 8] <= w_wdata[8*l +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the
    // pre-edge values; this also gives the debug port its read-before-write behaviour.
    always_ff @(posedge clk) begin
        if (!i_reset) r_dbg_data <= '0;
        else          r_dbg_data <= r_mem[i_dbg_addr];
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            r_mem2reg    <= 1'b0;
            r_regWrite   <= 1'b0;
            r_result     <= '0;
            r_write_reg  <= '0;
            r_misaligned <= 1'b0;
            r_width      <= W_BYTE;
            r_offset     <= 2'b00;
            r_sign       <= 1'b0;
            r_rd_word    <= '0;
        end else if (!i_halt) begin
            r_mem2reg    <= i_mem2reg;
            r_regWrite   <= i_regWrite && !w_misaligned;
            r_result     <= i_result;
            r_write_reg  <= i_write_reg;
            r_misaligned <= w_misaligned;
            r_width      <= w_width;
            r_offset     <= w_offset;
            r_sign       <= i_sign_flag;
            r_rd_word    <= r_mem[w_word_idx];
        end
    end

    // Lane selection and extension work on the registered access attributes.
    always_comb begin
        w_lane_byte = r_rd_word[7:0];
        case (r_offset)
            2'd1:    w_lane_byte = r_rd_word[15:8];
            2'd2:    w_lane_byte = r_rd_word[23:16];
            2'd3:    w_lane_byte = r_rd_word[31:24];
            default: w_lane_byte = r_rd_word[7:0];
        endcase
        w_lane_half = r_offset[1] ? r_rd_word[31:16] : r_rd_word[15:0];
        case (r_width)
            W_BYTE:  w_load_ext = {{24{r_sign & w_lane_byte[7]}}, w_lane_byte};
            W_HALF:  w_load_ext = {{16{r_sign & w_lane_half[15]}}, w_lane_half};
            default: w_load_ext = r_rd_word;
        endcase
    end

    assign o_read_data  = (r_mem2reg && !r_misaligned) ? w_load_ext : '0;
    assign o_mem2reg    = r_mem2reg;
    assign o_regWrite   = r_regWrite;
    assign o_result     = r_result;
    assign o_write_reg  = r_write_reg;
    assign o_misaligned = r_misaligned;
    assign o_dbg_data   = r_dbg_data;

endmodule
